// File: rtl/rx_filter_pkg.sv
// rtl/rx_filter_pkg.sv - shared widths and FSM encoding for the rx FIR filters
package rx_filter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } fir_state_t;

   // Ceiling log2, never below 1 so a 1-bit counter still has a port.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int acc_width(input int sample_w, input int coef_w, input int taps);
      return sample_w + coef_w + clog2(taps);
   endfunction

endpackage

// File: rtl/rx_fir_delay_line.sv
// rtl/rx_fir_delay_line.sv - circular sample store with write pointer and read-by-age port
module rx_fir_delay_line
   import rx_filter_pkg::*;
#(
   parameter int TAPS     = 200,
   parameter int SAMPLE_W = 16
) (
   input  logic                   crx_clk,
   input  logic                   rrx_rst_n,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [SAMPLE_W-1:0]    wr_data,
   input  logic [clog2(TAPS)-1:0] rd_off,
   output logic [SAMPLE_W-1:0]    rd_data
);

   localparam int AW = clog2(TAPS);

   logic [SAMPLE_W-1:0] line [TAPS];
   logic [AW-1:0]       wptr;
   logic [AW:0]         idx_sum;
   logic [AW-1:0]       rd_idx;

   always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
      if (!rrx_rst_n) begin
         wptr <= '0;
         for (int i = 0; i < TAPS; i++) line[i] <= '0;
      end else if (clr) begin
         wptr <= '0;
         for (int i = 0; i < TAPS; i++) line[i] <= '0;
      end else if (wr_en) begin
         line[wptr] <= wr_data;
         wptr       <= (wptr == AW'(TAPS - 1)) ? '0 : wptr + AW'(1);
      end
   end

   // Age k sits at (wptr-1-k) mod TAPS; bias by TAPS so the sum never goes negative.
   assign idx_sum = {1'b0, wptr} + (AW+1)'(TAPS - 1) - {1'b0, rd_off};
   assign rd_idx  = (idx_sum >= (AW+1)'(TAPS)) ? AW'(idx_sum - (AW+1)'(TAPS)) : AW'(idx_sum);
   assign rd_data = line[rd_idx];

endmodule

// File: rtl/rx_fir_mac.sv
// rtl/rx_fir_mac.sv - serial-MAC FIR with decimation, round/shift/saturate and overrun flag
module rx_fir_mac
   import rx_filter_pkg::*;
#(
   parameter int TAPS     = 200,
   parameter int SAMPLE_W = 16,
   parameter int COEF_W   = 16,
   parameter int OUT_W    = 32,
   parameter int SHIFT    = 0,
   parameter int DECIM    = 1
) (
   input  logic                   crx_clk,
   input  logic                   rrx_rst_n,
   input  logic                   erx_en,
   input  logic [SAMPLE_W-1:0]    isample,
   input  logic                   isample_valid,
   output logic                   osample_ready,
   output logic [clog2(TAPS)-1:0] ocoef_addr,
   input  logic [COEF_W-1:0]      icoef,
   output logic [OUT_W-1:0]       orsample,
   output logic                   osample_valid,
   output logic                   osat,
   output logic                   ooverrun
);

   localparam int AW    = clog2(TAPS);
   localparam int DW    = clog2(DECIM + 1);
   localparam int PW    = SAMPLE_W + COEF_W;
   localparam int ACC_W = acc_width(SAMPLE_W, COEF_W, TAPS);
   localparam int RW    = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;

   localparam logic signed [RW-1:0] RND  = RW'((64'd1 << SHIFT) >> 1);
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = ~OMAX;

   fir_state_t                 state;
   logic [AW-1:0]              k;
   logic [DW-1:0]              dcnt;
   logic signed [ACC_W-1:0]    acc;
   logic                       live_q;
   logic                       accept;
   logic [SAMPLE_W-1:0]        x_raw;
   logic signed [SAMPLE_W-1:0] x_s;
   logic signed [COEF_W-1:0]   coef_s;
   logic signed [PW-1:0]       prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [RW-1:0]       rnd;
   logic signed [RW-1:0]       shifted;
   logic                       clip_hi;
   logic                       clip_lo;
   logic [OUT_W-1:0]           sat_val;

   rx_fir_delay_line #(
      .TAPS     (TAPS),
      .SAMPLE_W (SAMPLE_W)
   ) u_line (
      .crx_clk   (crx_clk),
      .rrx_rst_n (rrx_rst_n),
      .clr       (~erx_en),
      .wr_en     (accept),
      .wr_data   (isample),
      .rd_off    (k),
      .rd_data   (x_raw)
   );

   // live_q keeps ready low until the first edge after reset release.
   assign osample_ready = erx_en & live_q & (state == ST_IDLE);
   assign accept        = isample_valid & osample_ready;
   assign ocoef_addr    = (state == ST_MAC) ? k : '0;

   assign x_s      = x_raw;
   assign coef_s   = icoef;
   assign prod     = PW'(x_s) * PW'(coef_s);
   assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

   assign rnd     = RW'(acc) + RND;
   assign shifted = rnd >>> SHIFT;
   assign clip_hi = shifted > OMAX;
   assign clip_lo = shifted < OMIN;
   assign sat_val = clip_hi ? OMAX[OUT_W-1:0] : (clip_lo ? OMIN[OUT_W-1:0] : shifted[OUT_W-1:0]);

   always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
      if (!rrx_rst_n) begin
         state         <= ST_IDLE;
         k             <= '0;
         dcnt          <= '0;
         acc           <= '0;
         live_q        <= 1'b0;
         orsample      <= '0;
         osample_valid <= 1'b0;
         osat          <= 1'b0;
         ooverrun      <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (!erx_en) begin
            state         <= ST_IDLE;
            k             <= '0;
            dcnt          <= '0;
            acc           <= '0;
            osample_valid <= 1'b0;
            osat          <= 1'b0;
            ooverrun      <= 1'b0;
         end else begin
            osample_valid <= 1'b0;
            osat          <= 1'b0;
            if (isample_valid && live_q && state != ST_IDLE) ooverrun <= 1'b1;
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     if (dcnt == DW'(DECIM - 1)) begin
                        dcnt  <= '0;
                        k     <= '0;
                        state <= ST_MAC;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end
               end
               ST_MAC: begin
                  acc <= (k == '0) ? prod_ext : acc + prod_ext;
                  if (k == AW'(TAPS - 1)) begin
                     k     <= '0;
                     state <= ST_OUT;
                  end else begin
                     k <= k + AW'(1);
                  end
               end
               ST_OUT: begin
                  orsample      <= sat_val;
                  osat          <= clip_hi | clip_lo;
                  osample_valid <= 1'b1;
                  state         <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_fir_mac.sv
// tb/tb_rx_fir_mac.sv - directed self-checking bench for rx_fir_mac
module tb_rx_fir_mac;

   logic crx_clk = 1'b0;
   always #5 crx_clk = ~crx_clk;

   logic               rst_n;
   logic               en;
   logic               valid;
   logic signed [15:0] sample;
   logic [1:0]         sel;
   logic [3:0]         en_v;

   logic [3:0]         rdy_v, vld_v, sat_v, ovr_v;
   logic [1:0]         a0, a1, a2, a3;
   logic [15:0]        c0, c1, c2, c3;
   logic [15:0]        rs0, rs1, rs2;
   logic [7:0]         rs3;

   logic               rdy, vld, sat, ovr;
   logic [1:0]         addr;
   logic signed [15:0] rs;

   logic [15:0] h0 [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
   logic [15:0] h1 [4] = '{16'd1, 16'd1, 16'd1, 16'd1};
   logic [15:0] h2 [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
   logic [15:0] h3 [4] = '{16'd127, 16'd127, 16'd0, 16'd0};

   int errors = 0;
   int checks = 0;

   assign en_v = en ? (4'b0001 << sel) : 4'b0000;
   assign c0 = h0[a0];
   assign c1 = h1[a1];
   assign c2 = h2[a2];
   assign c3 = h3[a3];

   always_comb begin
      rdy = rdy_v[sel];
      vld = vld_v[sel];
      sat = sat_v[sel];
      ovr = ovr_v[sel];
      case (sel)
         2'd1:    begin rs = rs1; addr = a1; end
         2'd2:    begin rs = rs2; addr = a2; end
         2'd3:    begin rs = {{8{rs3[7]}}, rs3}; addr = a3; end
         default: begin rs = rs0; addr = a0; end
      endcase
   end

   rx_fir_mac #(.TAPS(4), .SAMPLE_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0), .DECIM(1)) u_a (
      .crx_clk(crx_clk), .rrx_rst_n(rst_n), .erx_en(en_v[0]), .isample(sample),
      .isample_valid(valid), .osample_ready(rdy_v[0]), .ocoef_addr(a0), .icoef(c0),
      .orsample(rs0), .osample_valid(vld_v[0]), .osat(sat_v[0]), .ooverrun(ovr_v[0]));

   rx_fir_mac #(.TAPS(4), .SAMPLE_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0), .DECIM(2)) u_b (
      .crx_clk(crx_clk), .rrx_rst_n(rst_n), .erx_en(en_v[1]), .isample(sample),
      .isample_valid(valid), .osample_ready(rdy_v[1]), .ocoef_addr(a1), .icoef(c1),
      .orsample(rs1), .osample_valid(vld_v[1]), .osat(sat_v[1]), .ooverrun(ovr_v[1]));

   rx_fir_mac #(.TAPS(4), .SAMPLE_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(2), .DECIM(1)) u_c (
      .crx_clk(crx_clk), .rrx_rst_n(rst_n), .erx_en(en_v[2]), .isample(sample),
      .isample_valid(valid), .osample_ready(rdy_v[2]), .ocoef_addr(a2), .icoef(c2),
      .orsample(rs2), .osample_valid(vld_v[2]), .osat(sat_v[2]), .ooverrun(ovr_v[2]));

   rx_fir_mac #(.TAPS(4), .SAMPLE_W(16), .COEF_W(16), .OUT_W(8), .SHIFT(0), .DECIM(1)) u_d (
      .crx_clk(crx_clk), .rrx_rst_n(rst_n), .erx_en(en_v[3]), .isample(sample),
      .isample_valid(valid), .osample_ready(rdy_v[3]), .ocoef_addr(a3), .icoef(c3),
      .orsample(rs3), .osample_valid(vld_v[3]), .osat(sat_v[3]), .ooverrun(ovr_v[3]));

   // Offer one sample, then watch 12 edges; lat = edges from accept to first valid, -1 if none.
   task automatic push(input logic signed [15:0] s, output int lat,
                       output logic signed [15:0] val, output logic sat_o);
      int w;
      w = 0;
      while (!rdy && w < 40) begin
         @(negedge crx_clk);
         w++;
      end
      sample = s;
      valid  = 1'b1;
      @(posedge crx_clk);
      @(negedge crx_clk);
      valid = 1'b0;
      lat   = -1;
      val   = '0;
      sat_o = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge crx_clk);
         @(negedge crx_clk);
         if (vld && lat < 0) begin
            lat   = n;
            val   = rs;
            sat_o = sat;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; valid = 1'b0; sample = '0; sel = 2'd0;
      repeat (2) @(negedge crx_clk);
      checks++; if (rdy_v !== 4'b0) begin errors++; $display("FAIL reset ready: got %b want 0000", rdy_v); end
      checks++; if (vld_v !== 4'b0) begin errors++; $display("FAIL reset valid: got %b want 0000", vld_v); end
      checks++; if (sat_v !== 4'b0) begin errors++; $display("FAIL reset osat: got %b want 0000", sat_v); end
      checks++; if (ovr_v !== 4'b0) begin errors++; $display("FAIL reset overrun: got %b want 0000", ovr_v); end
      checks++; if (rs0 !== 16'd0 || rs3 !== 8'd0) begin errors++; $display("FAIL reset orsample: got %0d/%0d want 0/0", rs0, rs3); end
      checks++; if (a0 !== 2'd0) begin errors++; $display("FAIL reset coef_addr: got %0d want 0", a0); end
      rst_n = 1'b1;
      @(negedge crx_clk);
      en = 1'b1;
      #1;
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL ready after enable: got %b want 1", rdy); end
   endtask

   task automatic test_impulse(input string tag);
      logic signed [15:0] smp [5];
      logic signed [15:0] exp_v [5];
      int lat;
      logic signed [15:0] v;
      logic s;
      smp   = '{16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      exp_v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd0};
      sel = 2'd0;
      for (int i = 0; i < 5; i++) begin
         push(smp[i], lat, v, s);
         checks++; if (lat !== 5) begin errors++; $display("FAIL %s impulse[%0d] latency: got %0d want 5", tag, i, lat); end
         checks++; if (v !== exp_v[i]) begin errors++; $display("FAIL %s impulse[%0d] value: got %0d want %0d", tag, i, v, exp_v[i]); end
      end
   endtask

   task automatic test_decimation();
      logic signed [15:0] exp_v [3];
      int lat;
      logic signed [15:0] v;
      logic s;
      exp_v = '{16'sd3, 16'sd10, 16'sd18};
      sel = 2'd1;
      @(negedge crx_clk);
      for (int i = 0; i < 6; i++) begin
         push(16'(i + 1), lat, v, s);
         if (i % 2 == 0) begin
            checks++; if (lat !== -1) begin errors++; $display("FAIL decim odd accept %0d output: got latency %0d want none", i + 1, lat); end
         end else begin
            checks++; if (lat !== 5) begin errors++; $display("FAIL decim accept %0d latency: got %0d want 5", i + 1, lat); end
            checks++; if (v !== exp_v[i/2]) begin errors++; $display("FAIL decim accept %0d value: got %0d want %0d", i + 1, v, exp_v[i/2]); end
         end
      end
   endtask

   task automatic test_round_sat();
      int lat;
      logic signed [15:0] v;
      logic s;
      sel = 2'd2;
      @(negedge crx_clk);
      push(16'sd6, lat, v, s);
      checks++; if (v !== 16'sd2 || lat !== 5) begin errors++; $display("FAIL round +6: got %0d lat %0d want 2 lat 5", v, lat); end
      push(-16'sd6, lat, v, s);
      checks++; if (v !== -16'sd1) begin errors++; $display("FAIL round -6: got %0d want -1", v); end
      checks++; if (s !== 1'b0) begin errors++; $display("FAIL round osat: got %b want 0", s); end
      sel = 2'd3;
      @(negedge crx_clk);
      push(16'sd127, lat, v, s);
      checks++; if (v !== 16'sd127 || s !== 1'b1) begin errors++; $display("FAIL sat first: got %0d osat %b want 127 osat 1", v, s); end
      push(16'sd127, lat, v, s);
      checks++; if (v !== 16'sd127) begin errors++; $display("FAIL sat second value: got %0d want 127", v); end
      checks++; if (s !== 1'b1) begin errors++; $display("FAIL sat second osat: got %b want 1", s); end
   endtask

   task automatic test_overrun();
      int na, nv;
      logic o0, o1;
      sel = 2'd0;
      na = 0; nv = 0; o0 = 1'b0; o1 = 1'b0;
      @(negedge crx_clk);
      sample = 16'sd5;
      valid  = 1'b1;
      for (int i = 0; i < 14; i++) begin
         if (rdy) na++;
         @(posedge crx_clk);
         @(negedge crx_clk);
         if (vld) nv++;
         if (i == 0) o0 = ovr;
         if (i == 1) o1 = ovr;
      end
      checks++; if (na !== 3) begin errors++; $display("FAIL overrun accepts: got %0d want 3", na); end
      checks++; if (nv !== 2) begin errors++; $display("FAIL overrun outputs: got %0d want 2", nv); end
      checks++; if (o0 !== 1'b0 || o1 !== 1'b1) begin errors++; $display("FAIL overrun rise: got %b%b want 01", o0, o1); end
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun sticky: got %b want 1", ovr); end
      checks++; if (rs !== 16'sd15) begin errors++; $display("FAIL overrun held output: got %0d want 15", rs); end
      valid = 1'b0;
      en    = 1'b0;
      @(posedge crx_clk);
      @(negedge crx_clk);
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL overrun clear: got %b want 0", ovr); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ready while disabled: got %b want 0", rdy); end
      en = 1'b1;
      @(negedge crx_clk);
   endtask

   task automatic test_abort();
      int nv;
      sel = 2'd0;
      nv  = 0;
      sample = 16'sd7;
      valid  = 1'b1;
      @(posedge crx_clk);
      @(negedge crx_clk);
      valid = 1'b0;
      @(posedge crx_clk);
      @(posedge crx_clk);
      @(negedge crx_clk);
      checks++; if (addr !== 2'd2) begin errors++; $display("FAIL abort coef_addr at k2: got %0d want 2", addr); end
      en = 1'b0;
      #1;
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL abort ready disabled: got %b want 0", rdy); end
      @(posedge crx_clk);
      @(negedge crx_clk);
      checks++; if (addr !== 2'd0 || rdy !== 1'b0) begin errors++; $display("FAIL abort idle: got addr %0d ready %b want 0 0", addr, rdy); end
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge crx_clk);
         if (vld) nv++;
      end
      checks++; if (nv !== 0) begin errors++; $display("FAIL abort output pulses: got %0d want 0", nv); end
      test_impulse("after abort");
   endtask

   task automatic test_async_reset();
      int lat;
      logic signed [15:0] v;
      logic s;
      sel = 2'd0;
      push(16'sd9, lat, v, s);
      checks++; if (v !== 16'sd9) begin errors++; $display("FAIL pre-reset output: got %0d want 9", v); end
      sample = 16'sd3;
      valid  = 1'b1;
      @(posedge crx_clk);
      @(posedge crx_clk);
      @(posedge crx_clk);
      @(negedge crx_clk);
      checks++; if (ovr !== 1'b1 || addr !== 2'd2) begin errors++; $display("FAIL pre-reset state: got ovr %b addr %0d want 1 2", ovr, addr); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rdy !== 1'b0 || vld !== 1'b0 || sat !== 1'b0) begin errors++; $display("FAIL async reset flags: got rdy %b vld %b sat %b want 0 0 0", rdy, vld, sat); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL async reset overrun: got %b want 0", ovr); end
      checks++; if (rs !== 16'sd0 || addr !== 2'd0) begin errors++; $display("FAIL async reset data: got rs %0d addr %0d want 0 0", rs, addr); end
      valid = 1'b0;
      @(negedge crx_clk);
      rst_n = 1'b1;
      @(negedge crx_clk);
      test_impulse("after reset");
   endtask

   initial begin
      test_reset();
      test_impulse("power-on");
      test_decimation();
      test_round_sat();
      test_overrun();
      test_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
